// File: rtl/level_shifter_down.sv
// Clocked high-to-low level translator with hysteresis, debounce and supply supervision.
// Optional LS_DOWN_STICKY_FAULT_EN adds fault_sticky and latches S_OFF after a supply drop.
module level_shifter_down #(
  parameter real         TH_RISE    = 0.6,
  parameter real         TH_FALL    = 0.4,
  parameter real         VCC_MIN    = 0.9,
  parameter int unsigned DEB_CYCLES = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  real  VIN,
  input  real  VCC_HIGH,
  input  real  VCC_LOW,
  output real  VOUT,
  output logic dout,
  output logic valid,
  output logic rise_pulse,
`ifdef LS_DOWN_STICKY_FAULT_EN
  output logic fault_sticky,
`endif
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW,
    S_RISE_PEND,
    S_HIGH,
    S_FALL_PEND
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             fault_lock_c;

  logic             supply_ok_c;
  logic             in_hi_c;
  logic             in_lo_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // Analog qualification of supplies and input against VCC_HIGH-relative thresholds
  always_comb begin
    supply_ok_c = (VCC_HIGH >= VCC_MIN) && (VCC_LOW >= VCC_MIN) && (VCC_LOW <= VCC_HIGH);
    in_hi_c     = VIN > (TH_RISE * VCC_HIGH);
    in_lo_c     = VIN < (TH_FALL * VCC_HIGH);
    cnt_inc_c   = cnt_q + ONE_CNT;
  end

`ifdef LS_DOWN_STICKY_FAULT_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (!supply_ok_c && valid_q) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_lock_c = fault_q;
  assign fault_sticky = fault_q;
`else
  assign fault_lock_c = 1'b0;
`endif

  // Next-state and registered-output logic; a bad supply overrides every state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!supply_ok_c) begin
      state_d = S_OFF;
      cnt_d   = '0;
      dout_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          cnt_d  = '0;
          dout_d = 1'b0;
          if (!fault_lock_c) begin
            state_d = S_LOW;
            valid_d = 1'b1;
          end
        end
        S_LOW: begin
          if (in_hi_c) begin
            if (ONE_CNT == DEB_CNT) begin
              state_d = S_HIGH;
              cnt_d   = '0;
              dout_d  = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = S_RISE_PEND;
              cnt_d   = ONE_CNT;
            end
          end
        end
        S_RISE_PEND: begin
          if (!in_hi_c) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else if (cnt_inc_c == DEB_CNT) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        S_HIGH: begin
          if (in_lo_c) begin
            if (ONE_CNT == DEB_CNT) begin
              state_d = S_LOW;
              cnt_d   = '0;
              dout_d  = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = S_FALL_PEND;
              cnt_d   = ONE_CNT;
            end
          end
        end
        S_FALL_PEND: begin
          if (!in_lo_c) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else if (cnt_inc_c == DEB_CNT) begin
            state_d = S_LOW;
            cnt_d   = '0;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
          dout_d  = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout       = dout_q;
  assign valid      = valid_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

  // Output follows VCC_LOW ripple directly while driven high
  assign VOUT = (valid_q && dout_q) ? VCC_LOW : 0.0;

endmodule

// File: tb/tb_level_shifter_down.sv
// Scoreboard bench for level_shifter_down: a level/run-length reference model feeds
// an expectation queue that a per-cycle monitor drains.
module tb_level_shifter_down;

  localparam real         TH_RISE    = 0.6;
  localparam real         TH_FALL    = 0.4;
  localparam real         VCC_MIN    = 0.9;
  localparam int unsigned DEB_CYCLES = 3;

  logic clk;
  logic rst_n;
  real  VIN;
  real  VCC_HIGH;
  real  VCC_LOW;
  real  VOUT;
  logic dout;
  logic valid;
  logic rise_pulse;
  logic fall_pulse;
  logic fault_bit;

  int total;
  int bad;

`ifdef LS_DOWN_STICKY_FAULT_EN
  logic fault_sticky;
  assign fault_bit = fault_sticky;
`else
  assign fault_bit = 1'b0;
`endif

  level_shifter_down #(
    .TH_RISE(TH_RISE), .TH_FALL(TH_FALL), .VCC_MIN(VCC_MIN),
    .DEB_CYCLES(DEB_CYCLES), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .VIN(VIN),
    .VCC_HIGH(VCC_HIGH),
    .VCC_LOW(VCC_LOW),
    .VOUT(VOUT),
    .dout(dout),
    .valid(valid),
    .rise_pulse(rise_pulse),
`ifdef LS_DOWN_STICKY_FAULT_EN
    .fault_sticky(fault_sticky),
`endif
    .fall_pulse(fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: is the shifter powered, its output level, and how long the
  // input has consecutively argued for the opposite level.
  logic m_on;
  logic m_level;
  int   m_run;
  logic m_fault;

  logic [4:0] exp_bits_q[$];   // {fault, fall, rise, valid, dout}
  real        exp_vout_q[$];

  task automatic chk_bit(input string name, input logic act, input logic exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp_v);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real exp_v);
    real d;
    total++;
    d = act - exp_v;
    if (d < 0.0) d = -d;
    if (d > 1e-9) begin
      bad++;
      $display("FAIL %s at %0t: got %f want %f", name, $time, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_on    = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
    m_fault = 1'b0;
  endtask

  // Advance the model by one clock edge with the inputs currently applied
  task automatic model_edge();
    logic ok;
    logic qual;
    logic rise_e;
    logic fall_e;
    real  vo;
    ok     = (VCC_HIGH >= VCC_MIN) && (VCC_LOW >= VCC_MIN) && (VCC_LOW <= VCC_HIGH);
    rise_e = 1'b0;
    fall_e = 1'b0;
    if (!ok) begin
`ifdef LS_DOWN_STICKY_FAULT_EN
      if (m_on) m_fault = 1'b1;
`endif
      m_on    = 1'b0;
      m_level = 1'b0;
      m_run   = 0;
    end else if (!m_on) begin
      if (!m_fault) m_on = 1'b1;
      m_level = 1'b0;
      m_run   = 0;
    end else begin
      qual = m_level ? (VIN < TH_FALL * VCC_HIGH) : (VIN > TH_RISE * VCC_HIGH);
      m_run = qual ? m_run + 1 : 0;
      if (m_run == int'(DEB_CYCLES)) begin
        m_level = ~m_level;
        m_run   = 0;
        rise_e  = m_level;
        fall_e  = ~m_level;
      end
    end
    vo = (m_on && m_level) ? VCC_LOW : 0.0;
    exp_bits_q.push_back({m_fault, fall_e, rise_e, m_on, m_level});
    exp_vout_q.push_back(vo);
  endtask

  task automatic drive(input real vin, input real vh, input real vl);
    VIN      = vin;
    VCC_HIGH = vh;
    VCC_LOW  = vl;
    model_edge();
  endtask

  task automatic step(input real vin, input real vh, input real vl);
    @(negedge clk);
    drive(vin, vh, vl);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_bit({tag, "_dout"},  dout, 1'b0);
    chk_bit({tag, "_valid"}, valid, 1'b0);
    chk_bit({tag, "_rise"},  rise_pulse, 1'b0);
    chk_bit({tag, "_fall"},  fall_pulse, 1'b0);
    chk_bit({tag, "_fault"}, fault_bit, 1'b0);
    chk_real({tag, "_vout"}, VOUT, 0.0);
  endtask

  // Monitor: every edge with an outstanding expectation is compared
  initial begin
    logic [4:0] e;
    real        ev;
    forever begin
      @(posedge clk);
      #1;
      if (exp_bits_q.size() > 0) begin
        e  = exp_bits_q.pop_front();
        ev = exp_vout_q.pop_front();
        chk_bit("dout", dout, e[0]);
        chk_bit("valid", valid, e[1]);
        chk_bit("rise_pulse", rise_pulse, e[2]);
        chk_bit("fall_pulse", fall_pulse, e[3]);
        chk_bit("fault_sticky", fault_bit, e[4]);
        chk_bit("pulse_excl", rise_pulse & fall_pulse, 1'b0);
        chk_real("VOUT", VOUT, ev);
      end
    end
  end

  initial begin
    real vin_r;
    real vh_r;
    real vl_r;
    total = 0;
    bad   = 0;
    model_reset();

    // Power-up with VIN already high
    rst_n = 1'b0;
    VIN = 3.3; VCC_HIGH = 3.3; VCC_LOW = 1.2;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(3.3, 3.3, 1.2);
    repeat (5) step(3.3, 3.3, 1.2);

    // Hysteresis: return low, then probe between and on thresholds
    repeat (4) step(0.0, 3.3, 1.2);
    step(1.8, 3.3, 1.2);
    repeat (4) step(1.5, 3.3, 1.2);
    repeat (4) step(TH_RISE * 3.3, 3.3, 1.2);
    repeat (4) step(2.5, 3.3, 1.2);
    repeat (4) step(1.5, 3.3, 1.2);
    repeat (4) step(TH_FALL * 3.3, 3.3, 1.2);

    // Glitch rejection while high, with VCC_LOW ripple
    repeat (2) step(0.0, 3.3, 1.2);
    step(3.3, 3.3, 1.25);
    repeat (2) step(0.0, 3.3, 1.15);
    repeat (3) step(3.3, 3.3, 1.2);

    // Supply drop and recovery, then VCC_LOW above VCC_HIGH
    step(3.3, 3.3, 0.5);
    repeat (6) step(3.3, 3.3, 1.2);
    step(3.3, 1.0, 1.2);
    repeat (3) step(3.3, 3.3, 1.2);

    // Fall back low, then reset in the middle of a rising debounce
    repeat (6) step(0.0, 3.3, 1.2);
    repeat (2) step(3.3, 3.3, 1.2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    chk_bit("rst_hold_rise", rise_pulse, 1'b0);
    rst_n = 1'b1;
    drive(3.3, 3.3, 1.2);
    repeat (6) step(3.3, 3.3, 1.2);

    // Randomized phase: held input levels with occasional supply faults
    vin_r = 0.0; vh_r = 3.3; vl_r = 1.2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) vin_r = real'($urandom_range(0, 330)) / 100.0;
      vh_r = ($urandom_range(0, 40) == 0) ? 0.8 : 3.3;
      case ($urandom_range(0, 30))
        0:       vl_r = 0.5;
        1:       vl_r = 3.5;
        2:       vl_r = 1.8;
        default: vl_r = 1.2;
      endcase
      step(vin_r, vh_r, vl_r);
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_bits_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_bits_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
